// File: rtl/conv1_out_sink_pkg.sv
// Shared types and default sizing for the conv1 output sink.
// Holds the FSM state enum, default layer geometry and the drain read-cursor type.
// Cursor fields are sized generously so one type serves any CHAN/ADDR_W build.
package conv1_out_sink_pkg;

  localparam int CHAN   = 4;
  localparam int DATA_W = 8;
  localparam int OUTLEN = 2562;

  // Cursor field widths cover up to 256 channels and 64K entries per bank.
  localparam int CUR_CHAN_W = 8;
  localparam int CUR_ADDR_W = 16;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [CUR_CHAN_W-1:0] chan;
    logic [CUR_ADDR_W-1:0] addr;
  } cursor_t;

endpackage

// File: rtl/sink_bank_ram.sv
// Purpose: simple dual-port RAM holding one channel's feature map.
// Latency: write visible to a read issued on the next cycle; read data registered (1 cycle).
// Backpressure: none; rd_data holds its value while rd_en is low.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered result.
module sink_bank_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2562,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv1_out_sink.sv
// Purpose: capture conv layer 1 results into per-channel banks, then stream them out channel-major.
// Latency: first out_valid 2 cycles after entering DRAIN; one byte per cycle when out_ready stays high.
// Backpressure: valid/ready; output + skid register pair hold data stable while out_ready is low.
// Ports: clk, global_rst (async, active high); wr_valid/wr_addr/wr_data/wr_end from the layer;
//        out_valid/out_ready/out_data/out_chan/out_addr/out_last toward the next layer; done pulse; sticky err.
module conv1_out_sink #(
  parameter int CHAN   = conv1_out_sink_pkg::CHAN,
  parameter int DATA_W = conv1_out_sink_pkg::DATA_W,
  parameter int OUTLEN = conv1_out_sink_pkg::OUTLEN,
  parameter int ADDR_W = 12,
  parameter int CHAN_W = (CHAN > 1) ? $clog2(CHAN) : 1
) (
  input  logic                   clk,
  input  logic                   global_rst,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [CHAN*DATA_W-1:0] wr_data,
  input  logic                   wr_end,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CHAN_W-1:0]      out_chan,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_last,
  output logic                   done,
  output logic                   err
);

  import conv1_out_sink_pkg::*;

  localparam int RAM_AW = (OUTLEN > 1) ? $clog2(OUTLEN) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHAN_W-1:0] chan;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  state_t            state, state_nxt;
  logic              wr_en, err_set;
  logic              fire, issue, issue_done;
  logic              cur_last, cur_wrap;
  cursor_t           cur;
  logic [1:0]        occ_nxt;

  logic              p1_vld;
  logic [CHAN_W-1:0] p1_chan;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_last;
  logic [DATA_W-1:0] bank_rd [CHAN];

  beat_t             p1_beat, out_beat, skid_beat;
  logic              skid_vld;

  assign fire = out_valid && out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state <= CAPTURE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    case (state)
      CAPTURE: begin
        if (wr_valid) begin
          // One extra bit so OUTLEN == 2**ADDR_W still compares correctly.
          if ({1'b0, wr_addr} < (ADDR_W + 1)'(OUTLEN)) begin
            wr_en = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
        if (wr_end) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        err_set = wr_valid;
        if (fire && out_beat.last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        err_set   = wr_valid;
        done      = 1'b1;
        state_nxt = CAPTURE;
      end
      default: state_nxt = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- banks
  for (genvar c = 0; c < CHAN; c++) begin : g_bank
    sink_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (OUTLEN),
      .ADDR_W (RAM_AW)
    ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr[RAM_AW-1:0]),
      .wr_data (wr_data[c*DATA_W +: DATA_W]),
      .rd_en   (issue),
      .rd_addr (cur.addr[RAM_AW-1:0]),
      .rd_data (bank_rd[c])
    );
  end

  // ---------------------------------------------------------------- read cursor
  assign cur_wrap = (cur.addr == CUR_ADDR_W'(OUTLEN - 1));
  assign cur_last = cur_wrap && (cur.chan == CUR_CHAN_W'(CHAN - 1));

  // Bytes held after this edge (output + skid + the read in flight, minus one leaving).
  // A new read is only issued when that leaves a free slot for its data next cycle,
  // so the in-flight RAM result always has somewhere to land.
  assign occ_nxt = 2'(out_valid) + 2'(skid_vld) + 2'(p1_vld) - 2'(fire);
  assign issue   = (state == DRAIN) && !issue_done && (occ_nxt <= 2'd1);

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      cur        <= '0;
      issue_done <= 1'b0;
    end else if (state != DRAIN) begin
      cur        <= '0;
      issue_done <= 1'b0;
    end else if (issue) begin
      if (cur_last) begin
        issue_done <= 1'b1;
      end else if (cur_wrap) begin
        cur.addr <= '0;
        cur.chan <= cur.chan + CUR_CHAN_W'(1);
      end else begin
        cur.addr <= cur.addr + CUR_ADDR_W'(1);
      end
    end
  end

  // Tag travelling alongside the registered bank read.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      p1_vld  <= 1'b0;
      p1_chan <= '0;
      p1_addr <= '0;
      p1_last <= 1'b0;
    end else begin
      p1_vld <= issue;
      if (issue) begin
        p1_chan <= cur.chan[CHAN_W-1:0];
        p1_addr <= cur.addr[ADDR_W-1:0];
        p1_last <= cur_last;
      end
    end
  end

  always_comb begin
    p1_beat      = '0;
    p1_beat.data = bank_rd[p1_chan];
    p1_beat.chan = p1_chan;
    p1_beat.addr = p1_addr;
    p1_beat.last = p1_last;
  end

  // ---------------------------------------------------------------- output / skid
  // out_beat is always the oldest byte, skid_beat the next one.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      skid_vld  <= 1'b0;
      skid_beat <= '0;
    end else if (out_valid && !out_ready) begin
      if (!skid_vld && p1_vld) begin
        skid_vld  <= 1'b1;
        skid_beat <= p1_beat;
      end
    end else if (skid_vld) begin
      out_valid <= 1'b1;
      out_beat  <= skid_beat;
      skid_vld  <= p1_vld;
      if (p1_vld) begin
        skid_beat <= p1_beat;
      end
    end else begin
      out_valid <= p1_vld;
      if (p1_vld) begin
        out_beat <= p1_beat;
      end
    end
  end

  assign out_data = out_beat.data;
  assign out_chan = out_beat.chan;
  assign out_addr = out_beat.addr;
  assign out_last = out_beat.last;

endmodule

// File: tb/tb_conv1_out_sink.sv
module tb_conv1_out_sink;

  localparam int CHAN   = 4;
  localparam int DATA_W = 8;
  localparam int OUTLEN = 6;
  localparam int ADDR_W = 12;
  localparam int CHAN_W = 2;
  localparam int NB     = CHAN * OUTLEN;

  logic                   clk = 1'b0;
  logic                   global_rst;
  logic                   wr_valid;
  logic [ADDR_W-1:0]      wr_addr;
  logic [CHAN*DATA_W-1:0] wr_data;
  logic                   wr_end;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CHAN_W-1:0]      out_chan;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_last;
  logic                   done;
  logic                   err;

  always #5 clk = ~clk;

  conv1_out_sink #(
    .CHAN   (CHAN),
    .DATA_W (DATA_W),
    .OUTLEN (OUTLEN),
    .ADDR_W (ADDR_W),
    .CHAN_W (CHAN_W)
  ) dut (
    .clk        (clk),
    .global_rst (global_rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_end     (wr_end),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .done       (done),
    .err        (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: bank contents as a plain 2-D array plus the expected sticky error.
  logic [7:0] mdl [CHAN][OUTLEN];
  bit         err_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] basic_word(input int a);
    return {8'(48 + a), 8'(32 + a), 8'(16 + a), 8'(a)};
  endfunction

  task automatic mdl_write(input int a, input logic [31:0] d);
    if (a < OUTLEN) begin
      for (int c = 0; c < CHAN; c++) mdl[c][a] = d[c*8 +: 8];
    end else begin
      err_exp = 1'b1;
    end
  endtask

  task automatic cap_write(input int a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic capture_basic();
    for (int a = 0; a < OUTLEN; a++) cap_write(a, basic_word(a));
  endtask

  task automatic capture_random();
    int extra;
    for (int a = 0; a < OUTLEN; a++) cap_write(a, $urandom);
    extra = $urandom_range(1, 4);
    for (int k = 0; k < extra; k++) begin
      if ($urandom_range(0, 1) == 1) tick();
      cap_write($urandom_range(0, OUTLEN - 1), $urandom);
    end
  endtask

  // Pulse wr_end (optionally with a same-cycle write); optionally check drain start latency.
  task automatic start_drain(input bit with_wr, input int a, input logic [31:0] d, input bit chk_lat);
    wr_end    = 1'b1;
    out_ready = 1'b1;
    if (with_wr) begin
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = d;
    end
    tick();
    wr_end   = 1'b0;
    wr_valid = 1'b0;
    if (with_wr) mdl_write(a, d);
    if (chk_lat) begin
      chk("lat_edge0", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge1", 32'(out_valid), 32'd0);
      tick();
      chk("lat_edge2", 32'(out_valid), 32'd1);
    end
  endtask

  // mode 0: ready always high; 1: fixed 1,0,0,1,0,1 pattern; 2: random ready.
  task automatic drain(input int mode, input int stop_after, input bit poke);
    logic [7:0]  exp_q [NB];
    int          got = 0;
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] held = '0;
    bit          rdy;
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < NB; i++) exp_q[i] = mdl[i / OUTLEN][i % OUTLEN];
    while (got < stop_after && cyc < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 6];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (poke) begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_addr  = ADDR_W'($urandom_range(0, 7));
        wr_data  = $urandom;
        wr_end   = 1'($urandom_range(0, 1));
        if (wr_valid) err_exp = 1'b1;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", {9'd0, out_data, out_chan, out_addr, out_last}, held);
      end
      if (out_valid && rdy) begin
        chk("byte_data", 32'(out_data), 32'(exp_q[got]));
        chk("byte_chan", 32'(out_chan), 32'(got / OUTLEN));
        chk("byte_addr", 32'(out_addr), 32'(got % OUTLEN));
        chk("byte_last", 32'(out_last), 32'(got == NB - 1));
        got++;
      end
      prev_stall = out_valid && !rdy;
      held       = {9'd0, out_data, out_chan, out_addr, out_last};
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    wr_end   = 1'b0;
    if (got < stop_after) chk("drain_timeout", 32'(got), 32'(stop_after));
  endtask

  task automatic finish_drain();
    chk("done_pulse", 32'(done), 32'd1);
    chk("idle_after_last", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("err_flag", 32'(err), 32'(err_exp));
  endtask

  initial begin
    global_rst = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_end     = 1'b0;
    out_ready  = 1'b0;
    err_exp    = 1'b0;
    for (int c = 0; c < CHAN; c++)
      for (int a = 0; a < OUTLEN; a++) mdl[c][a] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    global_rst = 1'b0;
    tick();

    // Basic capture and drain with ready held high.
    capture_basic();
    start_drain(1'b0, 0, '0, 1'b1);
    drain(0, NB, 1'b0);
    finish_drain();

    // Overwrite within capture, plus a write on the same cycle as wr_end.
    capture_random();
    cap_write(2, $urandom);
    start_drain(1'b1, 5, $urandom, 1'b0);
    drain(2, NB, 1'b0);
    finish_drain();

    // Backpressure pattern.
    capture_basic();
    start_drain(1'b0, 0, '0, 1'b1);
    drain(1, NB, 1'b0);
    finish_drain();

    // Out-of-range address: flagged, no bank changes.
    capture_basic();
    cap_write(6, 32'hDEADBEEF);
    chk("err_range", 32'(err), 32'd1);
    cap_write($urandom_range(7, 4095), $urandom);
    start_drain(1'b0, 0, '0, 1'b0);
    drain(0, NB, 1'b0);
    finish_drain();

    // Reset after 10 bytes: output drops at once, drain does not resume.
    capture_random();
    start_drain(1'b0, 0, '0, 1'b0);
    drain(0, 10, 1'b0);
    global_rst = 1'b1;
    err_exp    = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    tick();
    global_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_resume", 32'(out_valid), 32'd0);
    end

    // Fresh capture after reset, with writes and wr_end pokes during the drain.
    capture_random();
    start_drain(1'b0, 0, '0, 1'b1);
    drain(2, NB, 1'b1);
    finish_drain();

    // Random rounds.
    for (int r = 0; r < 3; r++) begin
      capture_random();
      start_drain(1'($urandom_range(0, 1)), $urandom_range(0, OUTLEN - 1), $urandom, 1'b0);
      drain(2, NB, 1'($urandom_range(0, 1)));
      finish_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv1_out_sink.md
# conv1_out_sink

Receiving end of the first convolution layer's output interface. Captures the per-channel 8-bit results that the layer qualifies with `valid_conv` and addresses with `outcount1` into one on-chip bank per channel. After the layer's end-of-layer pulse it streams the stored feature maps out one byte per cycle, channel-major, over a valid/ready handshake toward the next layer's activation input.

## Interface
- `CHAN`, 4: number of output channels, one bank each.
- `DATA_W`, 8: width of each channel result.
- `OUTLEN`, 2562: entries per channel bank; valid addresses are 0..OUTLEN-1.
- `ADDR_W`, 12: width of `wr_addr` and `out_addr`; must satisfy 2^ADDR_W ≥ OUTLEN.
- `clk` in 1: single clock, rising edge.
- `global_rst` in 1: asynchronous, active-high reset.
- `wr_valid` in 1: layer result valid; connects to `valid_conv`.
- `wr_addr` in ADDR_W: result index; connects to `outcount1`.
- `wr_data` in CHAN*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W]; connects to `data_outm1..4` concatenated.
- `wr_end` in 1: end-of-layer pulse; connects to `end_conlay1`.
- `out_valid` out 1: `out_data` holds a valid byte.
- `out_ready` in 1: downstream accepts the byte.
- `out_data` out DATA_W: streamed result.
- `out_chan` out clog2(CHAN): channel of `out_data`.
- `out_addr` out ADDR_W: index of `out_data` within its channel.
- `out_last` out 1: final byte of the drain (channel CHAN-1, index OUTLEN-1).
- `done` out 1: one-cycle pulse after the last handshake.
- `err` out 1: sticky; set on an out-of-range address or a write outside CAPTURE.

## Operation
- States: CAPTURE, DRAIN, DONE. The reset state is CAPTURE.
- CAPTURE:
  - When `wr_valid`=1 and `wr_addr`<OUTLEN, write every channel slice of `wr_data` to bank[c][wr_addr].
  - When `wr_valid`=1 and `wr_addr`≥OUTLEN, do not write and set `err`.
  - A repeated address overwrites the earlier entry; last write wins.
- `wr_end`=1 in CAPTURE moves the state to DRAIN. If `wr_valid` is asserted in the same cycle, that write is still performed.
- DRAIN:
  - Read order is chan 0, addresses 0..OUTLEN-1, then chan 1, and so on through chan CHAN-1.
  - A byte transfers when `out_valid` and `out_ready` are both high.
  - `out_last`=1 only on the final byte.
  - The handshake that transfers the final byte moves the state to DONE.
- DONE lasts one cycle. `done`=1 during it, then the state returns to CAPTURE. Bank contents are retained, not cleared.
- Any `wr_valid` or `wr_end` during DRAIN or DONE is ignored. A `wr_valid` in those states also sets `err`.
- `err` clears only on `global_rst`.
- Entries that were never written drain with whatever value they hold; after power-up that value is undefined.

## Timing
- Reset values: state=CAPTURE; `out_valid`, `out_last`, `done`, `err` = 0; `out_data`, `out_chan`, `out_addr` = 0. Bank contents are not reset.
- Write latency: data written at edge t is readable from edge t+1.
- Bank read latency is 1 cycle. The first `out_valid`=1 appears exactly 2 cycles after the edge that enters DRAIN.
- With `out_ready` held high, the block transfers one byte every cycle with no bubbles. A full drain is CHAN*OUTLEN cycles after the first valid byte.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_chan`, `out_addr` and `out_last` hold stable. `out_valid` never drops without a handshake.
- The prefetch read and the held output must not lose or duplicate a byte when `out_ready` toggles every cycle. This requires a one-entry skid register.
- `global_rst` asserted mid-DRAIN: `out_valid` drops immediately, because the reset is asynchronous. The block restarts in CAPTURE, and the drain does not resume.

## Structure
- Package `conv1_out_sink_pkg` holds:
  - the state enum (CAPTURE, DRAIN, DONE);
  - default constants `CHAN`, `DATA_W`, `OUTLEN`;
  - the read-cursor type (chan, addr).
- Sub-module `sink_bank_ram`: a simple dual-port RAM, DATA_W×OUTLEN, one write port and one registered read port. Instantiate it CHAN times in a generate loop.
- Top level contains:
  - the FSM;
  - a channel/address read cursor with wrap from OUTLEN-1 to 0 that increments the channel;
  - a CHAN:1 read mux;
  - the output/skid register pair.

## Test plan
- Test parameters are OUTLEN=6, CHAN=4.
- Basic capture and drain:
  - Stimulus: write addr 0..5 with ch c byte = 16*c+addr, then pulse `wr_end`; hold `out_ready`=1.
  - Required: 24 consecutive bytes 0x00..0x05, 0x10..0x15, 0x20..0x25, 0x30..0x35; `out_last` only on 0x35; `done` pulses one cycle later.
- Same-cycle end:
  - Stimulus: assert `wr_valid` with addr 5 in the same cycle as `wr_end`.
  - Required: byte 5 of every channel drains with the new value.
- Backpressure:
  - Stimulus: `out_ready` pattern 1,0,0,1,0,1,…
  - Required: an ordered 24-byte sequence identical to the basic case, no duplicates, and outputs stable while stalled.
- Error flagging:
  - Stimulus (a): `wr_addr`=6.
  - Stimulus (b): `wr_valid` during DRAIN.
  - Required: `err`=1 and stays 1; no bank content changes; drain order is unaffected.
- Reset mid-drain:
  - Stimulus: assert `global_rst` after 10 bytes; then run a new capture with fresh data.
  - Required: `out_valid`=0 at once, state is CAPTURE, and the new capture drains a full 24 bytes from ch0 addr0.
